wdt_window: RTL and testbench

- Parametrised windowed watchdog; next generation of the single-register peripheral watchdog.
- Adds a built-in prescaler, a configurable counter width, an early-kick window, an early-warning interrupt and a multi-cycle reset pulse.
- Sits on the peripheral bus as a 4-word register slot. Drives the SoC reset request and one interrupt line.

---
 rtl/wdt_pkg.sv | 28 ++
 rtl/wdt_window_if.sv | 30 +++
 rtl/wdt_prescaler.sv | 35 +++
 rtl/wdt_window.sv | 160 ++++++++++++++++
 tb/tb_wdt_window.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wdt_pkg.sv
//==============================================================================
// wdt_pkg : shared types and constants for the windowed watchdog
// Rev 1.0
//==============================================================================
`default_nettype none

package wdt_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUNNING  = 2'd1,
        FIRING   = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_KICK   = 2'd0;
    localparam logic [1:0] ADDR_WINDOW = 2'd1;
    localparam logic [1:0] ADDR_WARN   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_RUNNING  = 0;
    localparam int STAT_FIRING   = 1;
    localparam int STAT_EXPIRED  = 2;
    localparam int STAT_EARLY    = 3;
    localparam int STAT_WARN_IRQ = 4;

endpackage

`default_nettype wire

// File: rtl/wdt_window_if.sv
//==============================================================================
// wdt_window_if : register-slot bus plus reset/interrupt lines of the watchdog
// Rev 1.0
//==============================================================================
`default_nettype none

interface wdt_window_if #(
    parameter int CNT_W = 32
) ();

    logic             wr_en;
    logic [1:0]       addr;
    logic [CNT_W-1:0] wr_data;
    logic [CNT_W-1:0] rd_data;
    logic             warn_irq;
    logic             wdt_reset;

    modport master (
        output wr_en, addr, wr_data,
        input  rd_data, warn_irq, wdt_reset
    );

    modport slave (
        input  wr_en, addr, wr_data,
        output rd_data, warn_irq, wdt_reset
    );

endinterface

`default_nettype wire

// File: rtl/wdt_prescaler.sv
//==============================================================================
// wdt_prescaler : DIV-cycle tick generator with enable and synchronous clear
// Rev 1.0
//==============================================================================
`default_nettype none

module wdt_prescaler #(
    parameter int DIV = 25
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  wire logic clr,
    output logic      tick
);

    localparam int C_W = $clog2(DIV);

    logic [C_W-1:0] r_cnt;

    assign tick = en && (r_cnt == C_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + C_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/wdt_window.sv
//==============================================================================
// wdt_window : windowed watchdog with early-warning irq and timed reset pulse
// Rev 1.0
//==============================================================================
`default_nettype none

module wdt_window
    import wdt_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DIV        = 25,
    parameter int RST_CYCLES = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    wdt_window_if.slave bus
);

    localparam int FC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_load, w_load_nxt;
    logic [CNT_W-1:0] r_window, w_window_nxt;
    logic [CNT_W-1:0] r_warn, w_warn_nxt;
    logic             r_warn_irq, w_warn_irq_nxt;
    logic             r_expired, w_expired_nxt;
    logic             r_early, w_early_nxt;
    logic [FC_W-1:0]  r_fire_cnt, w_fire_cnt_nxt;

    logic             w_tick;
    logic             w_presc_clr;
    logic             w_kick;
    logic             w_window_ok;
    logic [CNT_W-1:0] w_elapsed;
    logic [CNT_W-1:0] w_count_dec;
    logic [CNT_W-1:0] w_status;

    wdt_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state == RUNNING),
        .clr   (w_presc_clr),
        .tick  (w_tick)
    );

    assign w_kick      = bus.wr_en && (bus.addr == ADDR_KICK) && (bus.wr_data != '0);
    // count <= load always holds, so this cannot underflow
    assign w_elapsed   = r_load - r_count;
    assign w_window_ok = (r_window == '0) || (w_elapsed >= r_window);
    assign w_count_dec = r_count - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= DISABLED;
            r_count    <= '0;
            r_load     <= '0;
            r_window   <= '0;
            r_warn     <= '0;
            r_warn_irq <= 1'b0;
            r_expired  <= 1'b0;
            r_early    <= 1'b0;
            r_fire_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_load     <= w_load_nxt;
            r_window   <= w_window_nxt;
            r_warn     <= w_warn_nxt;
            r_warn_irq <= w_warn_irq_nxt;
            r_expired  <= w_expired_nxt;
            r_early    <= w_early_nxt;
            r_fire_cnt <= w_fire_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_load_nxt     = r_load;
        w_window_nxt   = r_window;
        w_warn_nxt     = r_warn;
        w_warn_irq_nxt = r_warn_irq;
        w_expired_nxt  = r_expired;
        w_early_nxt    = r_early;
        w_fire_cnt_nxt = '0;
        w_presc_clr    = 1'b0;

        case (r_state)
            DISABLED: begin
                if (bus.wr_en && bus.addr == ADDR_WINDOW) w_window_nxt = bus.wr_data;
                if (bus.wr_en && bus.addr == ADDR_WARN)   w_warn_nxt   = bus.wr_data;
                if (w_kick) begin
                    w_load_nxt  = bus.wr_data;
                    w_count_nxt = bus.wr_data;
                    w_presc_clr = 1'b1;
                    w_state_nxt = RUNNING;
                end
            end
            RUNNING: begin
                // a kick takes priority over a coincident tick, valid or early
                if (w_kick && w_window_ok) begin
                    w_load_nxt     = bus.wr_data;
                    w_count_nxt    = bus.wr_data;
                    w_presc_clr    = 1'b1;
                    w_warn_irq_nxt = 1'b0;
                end else if (w_kick) begin
                    w_early_nxt    = 1'b1;
                    w_warn_irq_nxt = 1'b0;
                    w_state_nxt    = FIRING;
                end else if (w_tick) begin
                    w_count_nxt = w_count_dec;
                    if (r_count == CNT_W'(1)) begin
                        w_expired_nxt  = 1'b1;
                        w_warn_irq_nxt = 1'b0;
                        w_state_nxt    = FIRING;
                    end else if (r_warn != '0 && w_count_dec == r_warn) begin
                        w_warn_irq_nxt = 1'b1;
                    end
                end
            end
            FIRING: begin
                if (r_fire_cnt == FC_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = DISABLED;
                end else begin
                    w_fire_cnt_nxt = r_fire_cnt + FC_W'(1);
                end
            end
            default: begin
                w_state_nxt = DISABLED;
            end
        endcase
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_RUNNING]  = (r_state == RUNNING);
        w_status[STAT_FIRING]   = (r_state == FIRING);
        w_status[STAT_EXPIRED]  = r_expired;
        w_status[STAT_EARLY]    = r_early;
        w_status[STAT_WARN_IRQ] = r_warn_irq;
    end

    always_comb begin
        case (bus.addr)
            ADDR_KICK:   bus.rd_data = r_count;
            ADDR_WINDOW: bus.rd_data = r_window;
            ADDR_WARN:   bus.rd_data = r_warn;
            default:     bus.rd_data = w_status;
        endcase
    end

    assign bus.warn_irq  = r_warn_irq;
    assign bus.wdt_reset = (r_state == FIRING);

endmodule

`default_nettype wire

// File: tb/tb_wdt_window.sv
//==============================================================================
// tb_wdt_window : directed stimulus against a time-based behavioural model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_wdt_window;
    import wdt_pkg::*;

    localparam int CNT_W      = 16;
    localparam int DIV        = 4;
    localparam int RST_CYCLES = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    wdt_window_if #(.CNT_W(CNT_W)) bus ();

    wdt_window #(
        .CNT_W      (CNT_W),
        .DIV        (DIV),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: time measured in edges since the accepted kick ("age").
    int          m_state;   // 0 disabled, 1 running, 2 firing
    int          m_age;
    int          m_fage;
    int unsigned m_load, m_win, m_warn, m_hold;
    bit          m_irq, m_exp, m_early;

    function automatic int unsigned m_count();
        if (m_state == 1) return m_load - m_age / DIV;
        return m_hold;
    endfunction

    function automatic int unsigned m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_count();
            2'd1:    return m_win;
            2'd2:    return m_warn;
            default: return (m_state == 1 ? 1 : 0) | (m_state == 2 ? 2 : 0) |
                            (m_exp ? 4 : 0) | (m_early ? 8 : 0) | (m_irq ? 16 : 0);
        endcase
    endfunction

    always @(posedge clk) begin
        int unsigned wd;
        bit          kick;
        cyc++;
        wd   = bus.wr_data;
        kick = bus.wr_en && bus.addr == 2'd0 && wd != 0;
        if (!rst_n) begin
            m_state = 0; m_age = 0; m_fage = 0;
            m_load = 0; m_win = 0; m_warn = 0; m_hold = 0;
            m_irq = 0; m_exp = 0; m_early = 0;
        end else if (m_state == 0) begin
            if (bus.wr_en && bus.addr == 2'd1) m_win  = wd;
            if (bus.wr_en && bus.addr == 2'd2) m_warn = wd;
            if (kick) begin
                m_load = wd; m_age = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (kick && (m_win == 0 || m_age / DIV >= m_win)) begin
                m_load = wd; m_age = 0; m_irq = 0;
            end else if (kick) begin
                m_hold = m_load - m_age / DIV;
                m_early = 1; m_irq = 0; m_state = 2; m_fage = 0;
            end else begin
                m_age++;
                if (m_age == m_load * DIV) begin
                    m_hold = 0; m_exp = 1; m_irq = 0; m_state = 2; m_fage = 0;
                end else if (m_warn != 0 && m_warn < m_load && m_age == (m_load - m_warn) * DIV) begin
                    m_irq = 1;
                end
            end
        end else begin
            m_fage++;
            if (m_fage == RST_CYCLES) m_state = 0;
        end
    end

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("model_wdt_reset", 32'(bus.wdt_reset), (m_state == 2) ? 1 : 0);
            check("model_warn_irq",  32'(bus.warn_irq), 32'(m_irq));
            check("model_rd_data",   32'(bus.rd_data),  m_read(bus.addr));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input int unsigned d);
        bus.wr_en   = 1'b1;
        bus.addr    = a;
        bus.wr_data = CNT_W'(d);
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input int unsigned exp);
        bus.addr = a;
        #1;
        check(name, 32'(bus.rd_data), exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; bus.wr_en = 1'b0; bus.addr = ADDR_STATUS; bus.wr_data = '0;
        step(2);
        rst_n = 1'b1;
        rd("rst_kick", ADDR_KICK, 0);
        rd("rst_window", ADDR_WINDOW, 0);
        rd("rst_warn", ADDR_WARN, 0);
        rd("rst_status", ADDR_STATUS, 0);
        check("rst_wdt_reset", 32'(bus.wdt_reset), 0);

        // Expiry: kick 5 -> reset high after edges 20..22
        write(ADDR_KICK, 5);
        rd("run_status", ADDR_STATUS, 32'h01);
        step(19);
        check("pre_fire", 32'(bus.wdt_reset), 0);
        step(1);
        check("fire_20", 32'(bus.wdt_reset), 1);
        step(2);
        check("fire_22", 32'(bus.wdt_reset), 1);
        step(1);
        check("fire_end", 32'(bus.wdt_reset), 0);
        rd("exp_status", ADDR_STATUS, 32'h04);
        rd("exp_kick", ADDR_KICK, 0);

        // Zero kicks are ignored
        do_reset();
        write(ADDR_KICK, 0);
        rd("zero_kick_dis", ADDR_STATUS, 0);
        write(ADDR_KICK, 7);
        write(ADDR_KICK, 0);
        rd("zero_kick_run", ADDR_KICK, 7);
        step(3);
        rd("zero_kick_dec", ADDR_KICK, 6);

        // Early kick inside the window
        do_reset();
        write(ADDR_WINDOW, 3);
        write(ADDR_KICK, 10);
        step(7);
        write(ADDR_KICK, 10);
        check("early_fire", 32'(bus.wdt_reset), 1);
        rd("early_status", ADDR_STATUS, 32'h0A);
        step(3);
        rd("early_after", ADDR_STATUS, 32'h08);

        // Kick exactly at the window boundary reloads
        do_reset();
        write(ADDR_WINDOW, 3);
        write(ADDR_KICK, 10);
        step(15);
        write(ADDR_KICK, 10);
        rd("late_kick_cnt", ADDR_KICK, 10);
        rd("late_kick_st", ADDR_STATUS, 32'h01);

        // Warning interrupt and clear by kick
        do_reset();
        write(ADDR_WARN, 2);
        write(ADDR_KICK, 6);
        step(15);
        check("warn_pre", 32'(bus.warn_irq), 0);
        step(1);
        check("warn_rise", 32'(bus.warn_irq), 1);
        rd("warn_status", ADDR_STATUS, 32'h11);
        step(1);
        write(ADDR_KICK, 6);
        check("warn_clear", 32'(bus.warn_irq), 0);
        rd("warn_reload", ADDR_KICK, 6);

        // Config locked while running; kick on the final tick wins
        write(ADDR_WINDOW, 9);
        rd("win_locked", ADDR_WINDOW, 0);
        step(22);
        rd("final_cnt", ADDR_KICK, 1);
        write(ADDR_KICK, 6);
        check("final_no_fire", 32'(bus.wdt_reset), 0);
        rd("final_reload", ADDR_KICK, 6);
        step(1);
        check("final_no_fire2", 32'(bus.wdt_reset), 0);

        // Reset during FIRING
        do_reset();
        write(ADDR_WARN, 1);
        write(ADDR_KICK, 2);
        step(8);
        check("fire_first", 32'(bus.wdt_reset), 1);
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst_fire_drop", 32'(bus.wdt_reset), 0);
        rd("rst_fire_kick", ADDR_KICK, 0);
        rd("rst_fire_warn", ADDR_WARN, 0);
        rd("rst_fire_status", ADDR_STATUS, 0);
        write(ADDR_KICK, 0);
        rd("rst_fire_dis", ADDR_STATUS, 0);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
